// File: rtl/cheb_pkg.sv
// Shared definitions for the Chebyshev evaluator: width helper, accumulator state
// encoding and default word lengths used by both the term multiplier and the accumulator.
package cheb_pkg;

    localparam int CHEB_WL_IN  = 16;
    localparam int CHEB_DEGREE = 4;
    localparam int CHEB_WL_SAT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } cheb_state_e;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sat_narrow.sv
// Combinational signed saturator: clips a WL_WIDE value into WL_NARROW bits and
// flags when clipping happened.
module sat_narrow #(
    parameter int WL_WIDE   = 19,
    parameter int WL_NARROW = 16
) (
    input  logic signed [WL_WIDE-1:0]   din,
    output logic signed [WL_NARROW-1:0] dout,
    output logic                        clip
);

    // The value fits when every bit above the narrow sign bit equals that sign bit.
    logic [WL_WIDE-WL_NARROW:0] top_bits;

    assign top_bits = din[WL_WIDE-1:WL_NARROW-1];

    always_comb begin
        clip = !((&top_bits) || !(|top_bits));
        if (!clip) begin
            dout = din[WL_NARROW-1:0];
        end else if (din[WL_WIDE-1]) begin
            dout = {1'b1, {(WL_NARROW-1){1'b0}}};
        end else begin
            dout = {1'b0, {(WL_NARROW-1){1'b1}}};
        end
    end

endmodule

// File: rtl/cheb_term_accumulator.sv
// Streaming accumulator for the DEGREE+1 terms c_k*T_k(x) of one Chebyshev series.
// Build macro CHEB_ACC_SAT_EN: out_sum narrows to WL_SAT with saturation and out_sat is added.
module cheb_term_accumulator
    import cheb_pkg::*;
#(
    parameter int WL_IN  = CHEB_WL_IN,
    parameter int DEGREE = CHEB_DEGREE,
`ifdef CHEB_ACC_SAT_EN
    parameter int WL_SAT = CHEB_WL_SAT,
`endif
    localparam int WIDENING = clog2(DEGREE + 1),
    localparam int WL_OUT   = WL_IN + WIDENING,
    localparam int CNT_W    = clog2(DEGREE + 2)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [WL_IN-1:0]  in_term,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
`ifdef CHEB_ACC_SAT_EN
    output logic signed [WL_SAT-1:0] out_sum,
    output logic                     out_sat,
`else
    output logic signed [WL_OUT-1:0] out_sum,
`endif
    output logic [CNT_W-1:0]         out_count,
    output logic                     out_err_len,
    output cheb_state_e              dbg_state
);

    // Handshake: a term transfers on a rising edge with in_valid && in_ready, a result
    // on a rising edge with out_valid && out_ready; valid never waits on ready, and
    // out_sum/out_count/out_err_len stay stable while out_valid is high and not taken.

    cheb_state_e              state, state_next;
    logic signed [WL_OUT-1:0] acc, acc_next, sum_next;
    logic [CNT_W-1:0]         count, count_next, count_inc;
    logic                     accept, series_end;
    logic                     load_out, drop_out;

    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign dbg_state  = state;

    // acc is zero whenever a series has not started, so this is also the first-term value.
    assign sum_next   = acc + WL_OUT'(in_term);
    assign count_inc  = count + CNT_W'(1);
    assign series_end = in_last || (count_inc == CNT_W'(DEGREE + 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            acc   <= '0;
            count <= '0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        acc_next   = acc;
        count_next = count;
        load_out   = 1'b0;
        drop_out   = 1'b0;
        case (state)
            ST_IDLE, ST_ACCUM: begin
                if (accept) begin
                    if (series_end) begin
                        load_out   = 1'b1;
                        acc_next   = '0;
                        count_next = '0;
                        state_next = ST_HOLD;
                    end else begin
                        acc_next   = sum_next;
                        count_next = count_inc;
                        state_next = ST_ACCUM;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    if (accept && series_end) begin
                        // Back-to-back single-term series: hand off and reload at once.
                        load_out   = 1'b1;
                        acc_next   = '0;
                        count_next = '0;
                        state_next = ST_HOLD;
                    end else if (accept) begin
                        drop_out   = 1'b1;
                        acc_next   = sum_next;
                        count_next = count_inc;
                        state_next = ST_ACCUM;
                    end else begin
                        drop_out   = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                acc_next   = '0;
                count_next = '0;
            end
        endcase
    end

`ifdef CHEB_ACC_SAT_EN
    logic signed [WL_SAT-1:0] sum_sat;
    logic                     sum_clip;

    sat_narrow #(
        .WL_WIDE   (WL_OUT),
        .WL_NARROW (WL_SAT)
    ) u_sat_narrow (
        .din  (sum_next),
        .dout (sum_sat),
        .clip (sum_clip)
    );
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_sum     <= '0;
            out_count   <= '0;
            out_err_len <= 1'b0;
`ifdef CHEB_ACC_SAT_EN
            out_sat     <= 1'b0;
`endif
        end else if (load_out) begin
            out_valid   <= 1'b1;
            out_count   <= count_inc;
            out_err_len <= !in_last;
`ifdef CHEB_ACC_SAT_EN
            out_sum     <= sum_sat;
            out_sat     <= sum_clip;
`else
            out_sum     <= sum_next;
`endif
        end else if (drop_out) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cheb_term_accumulator.sv
// Self-checking bench for cheb_term_accumulator (WL_IN=8, DEGREE=3); results are
// checked against a scoreboard queue filled by a reference model of the series sum.
module tb_cheb_term_accumulator;
  import cheb_pkg::*;

  localparam int WL_IN  = 8;
  localparam int DEGREE = 3;
  localparam int WL_OUT = 10;
  localparam int CNT_W  = 3;
`ifdef CHEB_ACC_SAT_EN
  localparam int WL_SAT = 8;
  localparam int OW     = WL_SAT;
`else
  localparam int OW     = WL_OUT;
`endif
  // Packed result: {sat, err_len, count, sum}
  localparam int EXP_W  = 2 + CNT_W + OW;

  logic                    clock;
  logic                    reset;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WL_IN-1:0] in_term;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OW-1:0]    out_sum;
  logic [CNT_W-1:0]        out_count;
  logic                    out_err_len;
  cheb_state_e             dbg_state;
  logic                    sat_bit;

  int n_vec;
  int n_err;
  int cyc;
  int m_acc;
  int m_cnt;
  logic [EXP_W-1:0] exp_q[$];

`ifdef CHEB_ACC_SAT_EN
  logic out_sat;
  assign sat_bit = out_sat;

  cheb_term_accumulator #(
    .WL_IN  (WL_IN),
    .DEGREE (DEGREE),
    .WL_SAT (WL_SAT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_term     (in_term),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_sat     (out_sat),
    .out_count   (out_count),
    .out_err_len (out_err_len),
    .dbg_state   (dbg_state)
  );
`else
  assign sat_bit = 1'b0;

  cheb_term_accumulator #(
    .WL_IN  (WL_IN),
    .DEGREE (DEGREE)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_term     (in_term),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_count   (out_count),
    .out_err_len (out_err_len),
    .dbg_state   (dbg_state)
  );
`endif

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [EXP_W-1:0] make_exp(input int sum, input int cnt, input bit err);
    logic [OW-1:0] s;
    bit sat;
    int hi;
    int lo;
    sat = 1'b0;
    hi  = (2 ** (OW - 1)) - 1;
    lo  = -(2 ** (OW - 1));
`ifdef CHEB_ACC_SAT_EN
    if (sum > hi) begin
      s   = OW'(hi);
      sat = 1'b1;
    end else if (sum < lo) begin
      s   = OW'(lo);
      sat = 1'b1;
    end else begin
      s = OW'(sum);
    end
`else
    s = OW'(sum);
`endif
    return {sat, err, CNT_W'(cnt), s};
  endfunction

  task automatic model_term(input int term, input bit last);
    m_acc = m_acc + term;
    m_cnt = m_cnt + 1;
    if (last || m_cnt == DEGREE + 1) begin
      exp_q.push_back(make_exp(m_acc, m_cnt, !last));
      m_acc = 0;
      m_cnt = 0;
    end
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 after the edge that accepted the term.
  task automatic send_term(input int term, input bit last);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_term  = WL_IN'(term);
    in_last  = last;
    @(negedge clock);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clock);
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: in_ready stayed %0b, required 1 within 50 cycles", in_ready);
      in_valid = 1'b0;
      in_last  = 1'b0;
      return;
    end
    model_term(term, last);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clock) begin
    logic [EXP_W-1:0] obs;
    logic [EXP_W-1:0] e;
    if (!reset && out_valid && out_ready) begin
      obs = {sat_bit, out_err_len, out_count, out_sum};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL result_unexpected: got {sat,err,cnt,sum}=%h, required no output", obs);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          n_err++;
          $display("FAIL result: got {sat,err,cnt,sum}=%h, required %h", obs, e);
        end
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_term   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    n_vec++; if (out_sum !== '0) begin n_err++; $display("FAIL reset_out_sum: got %h, required 0", out_sum); end
    n_vec++; if (out_count !== '0) begin n_err++; $display("FAIL reset_out_count: got %0d, required 0", out_count); end
    n_vec++; if (out_err_len !== 1'b0) begin n_err++; $display("FAIL reset_err_len: got %b, required 0", out_err_len); end
    n_vec++; if (sat_bit !== 1'b0) begin n_err++; $display("FAIL reset_out_sat: got %b, required 0", sat_bit); end
    n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d, required %0d", dbg_state, ST_IDLE); end
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_max_pos;
    for (int i = 0; i < 3; i++) send_term(127, 1'b0);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL maxpos_early_valid: got %b, required 0", out_valid); end
    send_term(127, 1'b1);
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL maxpos_latency: got out_valid %b, required 1", out_valid); end
    n_vec++; if (out_count !== 3'd4) begin n_err++; $display("FAIL maxpos_count: got %0d, required 4", out_count); end
  endtask

  task automatic test_max_neg;
    for (int i = 0; i < 4; i++) send_term(-128, i == 3);
  endtask

  task automatic test_back_to_back;
    int start;
    start = cyc;
    for (int i = 0; i < 6; i++) begin
      send_term(5, 1'b1);
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready: got %b, required 1", in_ready); end
    end
    n_vec++; if (cyc - start !== 6) begin n_err++; $display("FAIL b2b_cycles: got %0d cycles, required 6", cyc - start); end
  endtask

  task automatic test_err_len;
    for (int i = 1; i <= 4; i++) send_term(i, 1'b0);
    n_vec++; if (out_err_len !== 1'b1) begin n_err++; $display("FAIL errlen_flag: got %b, required 1", out_err_len); end
    send_term(7, 1'b1);
    n_vec++; if (out_err_len !== 1'b0) begin n_err++; $display("FAIL errlen_clear: got %b, required 0", out_err_len); end
  endtask

  task automatic test_random;
    for (int s = 0; s < 8; s++) begin
      int len;
      len = $urandom_range(1, DEGREE + 1);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clock);
          #1;
        end
        send_term(int'($urandom_range(0, 255)) - 128, (i == len - 1) && ($urandom_range(0, 1) == 1));
      end
    end
    // close any series left open by the random framing
    if (m_cnt != 0) send_term(1, 1'b1);
  endtask

  task automatic test_backpressure;
    send_term(1, 1'b0);
    out_ready = 1'b0;
    send_term(2, 1'b1);
    in_valid = 1'b1;
    in_term  = WL_IN'(9);
    in_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b, required 0", in_ready); end
      n_vec++; if (out_sum !== OW'(3)) begin n_err++; $display("FAIL bp_sum_stable: got %0d, required 3", out_sum); end
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid: got %b, required 1", out_valid); end
    end
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    model_term(9, 1'b1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    n_vec++; if (out_sum !== OW'(9)) begin n_err++; $display("FAIL bp_reload: got %0d, required 9", out_sum); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release: got %b, required 1", in_ready); end
  endtask

  task automatic test_reset_mid_series;
    send_term(1, 1'b0);
    send_term(1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    n_vec++; if (out_sum !== '0) begin n_err++; $display("FAIL midrst_sum: got %h, required 0", out_sum); end
    n_vec++; if (out_count !== '0) begin n_err++; $display("FAIL midrst_count: got %0d, required 0", out_count); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b, required 0", out_valid); end
    n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL midrst_state: got %0d, required %0d", dbg_state, ST_IDLE); end
    m_acc = 0;
    m_cnt = 0;
    @(posedge clock);
    #2;
    reset = 1'b0;
    send_term(1, 1'b0);
    send_term(1, 1'b1);
  endtask

  task automatic drain;
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(posedge clock);
      waited++;
    end
    @(posedge clock);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  // ---------------- sequence & report ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    m_acc = 0;
    m_cnt = 0;
    test_reset();
    test_max_pos();
    test_max_neg();
    test_back_to_back();
    test_err_len();
    test_random();
    test_backpressure();
    test_reset_mid_series();
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
